// File: rtl/dma_write_sequencer.sv
// dma_write_sequencer
//   Sequences host-bound DMA writes. Host register writes set the DMA base
//   address (DMABASE) and start a run of N data TLPs (DMACTRL). Each TLP is
//   one header beat followed by TLP_QWORDS payload beats streamed straight
//   from the local source. The payload of TLP k lands at base+64+128*k.
//   After the last data TLP, a 64-bit completion token is written at the
//   base address so the host can poll for it.
//
// Ports
//   clk_in, rstn         clock, asynchronous active-low reset
//   cfg_wr_valid/index/data  register write strobe (0=DMABASE, 1=DMACTRL)
//   src_data/valid/ready payload source (valid/ready handshake)
//   tx_data/valid/sop/eop/ready  beat stream into the TX TLP formatter
//   dma_busy             high in every state except IDLE
//   dma_done             one-cycle pulse after the token beat is accepted
//   cfg_err              sticky; a register write arrived while busy
//   dbg_state            current FSM state encoding, for observation
//
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. A producer never lowers valid or changes data while waiting for
// ready, and valid never depends on ready.
module dma_write_sequencer #(
  parameter int          TLP_QWORDS  = 16,
  parameter int          COUNT_WIDTH = 10,
  parameter logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic        cfg_wr_valid,
  input  logic        cfg_wr_index,
  input  logic [31:0] cfg_wr_data,
  input  logic [63:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        cfg_err,
  output logic [2:0]  dbg_state
);

  localparam int          BEAT_W   = (TLP_QWORDS > 1) ? $clog2(TLP_QWORDS) : 1;
  localparam logic [9:0]  DATA_LEN = 10'(2 * TLP_QWORDS);  // length in dwords
  localparam logic [9:0]  TOK_LEN  = 10'd2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TLP_QWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_DATA     = 3'd2,
    S_TOK_HDR  = 3'd3,
    S_TOK_DATA = 3'd4
  } state_t;

  state_t                 state;
  logic [31:0]            base;
  logic [31:0]            tlp_addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [BEAT_W-1:0]      beat;

  logic [COUNT_WIDTH-1:0] ctrl_n;
  logic                   data_fire;
  logic                   last_beat;

  assign ctrl_n    = cfg_wr_data[COUNT_WIDTH-1:0];
  assign last_beat = (beat == LAST_BEAT);
  assign data_fire = (state == S_DATA) && src_valid && tx_ready;
  assign dbg_state = state;
  assign dma_busy  = (state != S_IDLE);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      base      <= '0;
      tlp_addr  <= '0;
      remaining <= '0;
      beat      <= '0;
      dma_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      dma_done <= 1'b0;

      // Register writes only take effect in IDLE; anything else is dropped.
      if (cfg_wr_valid) begin
        if (state != S_IDLE) begin
          cfg_err <= 1'b1;
        end else if (!cfg_wr_index) begin
          base <= {cfg_wr_data[31:3], 3'b000};
        end else if (ctrl_n != '0) begin
          remaining <= ctrl_n;
          tlp_addr  <= base + 32'd64;   // token occupies the first 64 bytes
          state     <= S_HDR;
        end
      end

      case (state)
        S_HDR: begin
          if (tx_ready) begin
            state <= S_DATA;
            beat  <= '0;
          end
        end
        S_DATA: begin
          if (data_fire) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              tlp_addr  <= tlp_addr + 32'd128;
              remaining <= remaining - 1'b1;
              state     <= (remaining > 1) ? S_HDR : S_TOK_HDR;
            end
          end
        end
        S_TOK_HDR: begin
          if (tx_ready) state <= S_TOK_DATA;
        end
        S_TOK_DATA: begin
          if (tx_ready) begin
            state    <= S_IDLE;
            dma_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat outputs are decoded from registered state; DATA is a pass-through
  // of the source so payload flows with zero bubbles.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    src_ready = 1'b0;
    case (state)
      S_HDR: begin
        tx_data  = {tlp_addr, 22'b0, DATA_LEN};
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
      end
      S_DATA: begin
        tx_data   = src_data;
        tx_valid  = src_valid;
        tx_eop    = last_beat;
        src_ready = tx_ready;
      end
      S_TOK_HDR: begin
        tx_data  = {base, 22'b0, TOK_LEN};
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
      end
      S_TOK_DATA: begin
        tx_data  = TOKEN;
        tx_valid = 1'b1;
        tx_eop   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_write_sequencer.sv
module tb_dma_write_sequencer;

  localparam int          QW    = 16;
  localparam logic [63:0] TOKEN = 64'hCAFEF00DC0DEFACE;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rstn   = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        cfg_wr_valid = 1'b0;
  logic        cfg_wr_index = 1'b0;
  logic [31:0] cfg_wr_data  = '0;
  logic [63:0] src_data     = '0;
  logic        src_valid    = 1'b0;
  logic        src_ready;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop;
  logic        tx_ready     = 1'b1;
  logic        dma_busy, dma_done, cfg_err;
  logic [2:0]  dbg_state;

  dma_write_sequencer dut (
    .clk_in(clk_in), .rstn(rstn),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_index(cfg_wr_index), .cfg_wr_data(cfg_wr_data),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_ready(tx_ready), .dma_busy(dma_busy), .dma_done(dma_done),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [65:0] exp_q[$];      // {sop, eop, data}
  logic [63:0] src_q[$];      // qwords still to be offered by the source
  logic [63:0] src_list[$];   // full payload of the current run
  int cyc = 0, done_cnt = 0, done_cyc = 0, act_cnt = 0, wr_cyc = 0;
  bit stall_mode = 1'b0, src_fire = 1'b0, prev_stall = 1'b0, got_first = 1'b0;
  logic [65:0] prev_beat = '0;
  logic [31:0] first_hdr = '0, last_hdr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc++;

  // ---------------- source / sink driver ----------------
  always @(posedge clk_in) begin
    if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
    #2;
    // an offered qword is held until it is taken
    if (!(src_valid && !src_fire) || src_q.size() == 0)
      src_valid = (src_q.size() > 0) && (!stall_mode || $urandom_range(1, 0) == 1);
    src_data = (src_q.size() > 0) ? src_q[0] : 64'd0;
    tx_ready = !stall_mode || ($urandom_range(1, 0) == 1);
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk_in) begin
    if (!rstn) begin
      prev_stall = 1'b0;
      src_fire   = 1'b0;
    end else begin
      src_fire = src_valid && src_ready;
      if (prev_stall)
        check("stall_hold", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, prev_beat});
      prev_stall = tx_valid && !tx_ready;
      prev_beat  = {tx_sop, tx_eop, tx_data};
      if (tx_valid) act_cnt++;
      if (tx_valid && tx_ready) begin
        if (tx_sop) begin
          if (!got_first) first_hdr = tx_data[63:32];
          got_first = 1'b1;
          last_hdr  = tx_data[63:32];
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got sop=%0b eop=%0b data=%0h expected no beat",
                   tx_sop, tx_eop, tx_data);
        end else begin
          check("tx_beat", {tx_sop, tx_eop, tx_data}, exp_q.pop_front());
        end
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", dma_busy, 1'b0);
      end
    end
  end

  // ---------------- reference model ----------------
  // Whole-run view: N TLPs at base+64+128k, each header then its 16 qwords
  // in source order, then the token header at base and the token itself.
  task automatic build_expected(input logic [31:0] base_w, input int n);
    logic [31:0] b, a;
    b = base_w & 32'hFFFF_FFF8;
    for (int t = 0; t < n; t++) begin
      a = b + 32'd64 + 32'(128 * t);
      exp_q.push_back({1'b1, 1'b0, a, 22'b0, 10'd32});
      for (int q = 0; q < QW; q++)
        exp_q.push_back({1'b0, (q == QW - 1), src_list[t * QW + q]});
    end
    exp_q.push_back({1'b1, 1'b0, b, 22'b0, 10'd2});
    exp_q.push_back({1'b0, 1'b1, TOKEN});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic idx, input logic [31:0] data);
    @(posedge clk_in); #1;
    cfg_wr_valid = 1'b1;
    cfg_wr_index = idx;
    cfg_wr_data  = data;
    @(posedge clk_in); #1;
    wr_cyc       = cyc;          // cyc of the edge that sampled the write
    cfg_wr_valid = 1'b0;
  endtask

  task automatic prep_run(input int n, input bit stall);
    src_q.delete();
    src_list.delete();
    exp_q.delete();
    for (int i = 0; i < n * QW; i++) begin
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      src_list.push_back(w);
      src_q.push_back(w);
    end
    stall_mode = stall;
    done_cnt   = 0;
    act_cnt    = 0;
    got_first  = 1'b0;
  endtask

  int run_lat;
  task automatic run_dma(input logic [31:0] base_w, input logic [31:0] ctrl,
                         input bit stall, input bit mid);
    int n, start;
    n = int'(ctrl[9:0]);
    prep_run(n, stall);
    build_expected(base_w, n);
    cfg_write(1'b0, base_w);
    act_cnt = 0;
    cfg_write(1'b1, ctrl);
    start = wr_cyc;
    if (mid) begin
      repeat (8) @(posedge clk_in);
      cfg_write(1'b1, 32'd7);
      cfg_write(1'b0, 32'h5555_0000);
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk_in);
    repeat (4) @(posedge clk_in);
    #1;
    run_lat = done_cyc - (start - 1);
    check("done_count", done_cnt, 1);
    check("beats_left", exp_q.size(), 0);
    check("busy_after", dma_busy, 1'b0);
    stall_mode = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] base;
    int          n;
    bit          stall;
    bit          mid;
    logic [31:0] exp_first;
    logic [31:0] exp_tok;
    int          exp_lat;   // cycles from write cycle to dma_done cycle, -1 = skip
    int          exp_act;   // tx_valid cycles, -1 = skip
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0020, 1, 1'b0, 1'b0, 32'h0000_0060, 32'h0000_0020, 20, 19, 1'b0};
    vecs[1] = '{32'h0000_1000, 3, 1'b0, 1'b0, 32'h0000_1040, 32'h0000_1000, 54, 53, 1'b0};
    vecs[2] = '{32'hFFFF_FFC3, 2, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFC0, 37, 36, 1'b0};
    vecs[3] = '{32'h0000_1000, 3, 1'b1, 1'b0, 32'h0000_1040, 32'h0000_1000, -1, -1, 1'b0};
    vecs[4] = '{32'h0000_2000, 2, 1'b0, 1'b1, 32'h0000_2040, 32'h0000_2000, 37, 36, 1'b1};

    // reset values
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_sop", tx_sop, 1'b0);
    check("rst_tx_eop", tx_eop, 1'b0);
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_busy", dma_busy, 1'b0);
    check("rst_done", dma_done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    repeat (2) @(posedge clk_in);
    #1 rstn = 1'b1;

    // DMACTRL=0 (upper bits set) in IDLE: nothing happens
    prep_run(0, 1'b0);
    cfg_write(1'b1, 32'hFFFF_FC00);
    repeat (20) @(posedge clk_in);
    #1;
    check("n0_activity", act_cnt, 0);
    check("n0_cfg_err", cfg_err, 1'b0);
    check("n0_busy", dma_busy, 1'b0);
    check("n0_done", done_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      run_dma(vecs[v].base, 32'(vecs[v].n), vecs[v].stall, vecs[v].mid);
      check("first_hdr_addr", first_hdr, vecs[v].exp_first);
      check("tok_hdr_addr", last_hdr, vecs[v].exp_tok);
      check("cfg_err", cfg_err, vecs[v].exp_err);
      if (vecs[v].exp_lat >= 0) begin
        check("done_latency", run_lat, vecs[v].exp_lat);
        check("active_cycles", act_cnt, vecs[v].exp_act);
      end
    end

    // reset in the middle of DATA
    prep_run(2, 1'b0);
    build_expected(32'h400, 2);
    cfg_write(1'b0, 32'h400);
    cfg_write(1'b1, 32'd2);
    repeat (5) @(posedge clk_in);
    #3 rstn = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_tx_sop_eop", {tx_sop, tx_eop}, 2'b00);
    check("arst_tx_data", tx_data, 64'd0);
    check("arst_src_ready", src_ready, 1'b0);
    check("arst_busy", dma_busy, 1'b0);
    check("arst_done", dma_done, 1'b0);
    check("arst_cfg_err", cfg_err, 1'b0);
    exp_q.delete();
    done_cnt = 0;
    act_cnt  = 0;
    @(posedge clk_in); #1 rstn = 1'b1;
    repeat (25) @(posedge clk_in);
    #1;
    check("post_rst_state", dbg_state, 3'd0);
    check("post_rst_activity", act_cnt, 0);
    check("post_rst_no_token", done_cnt, 0);
    run_dma(32'h20, 32'd1, 1'b0, 1'b0);
    check("post_rst_latency", run_lat, 20);
    check("post_rst_tok_addr", last_hdr, 32'h20);

    // randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      logic [31:0] b, ctrl;
      int n;
      b    = $urandom();
      n    = $urandom_range(4, 1);
      ctrl = ($urandom() & 32'hFFFF_FC00) | 32'(n);
      run_dma(b, ctrl, ($urandom_range(1, 0) == 1), 1'b0);
      check("rand_tok_addr", last_hdr, b & 32'hFFFF_FFF8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_write_sequencer.md
# dma_write_sequencer

FPGA-side controller that sequences host-bound DMA writes for the pcie-dma application. It accepts host register writes to DMABASE/DMACTRL and streams the requested number of 128-byte memory-write TLPs from a local 64-bit source into the TX TLP formatter. It then writes a 64-bit completion token at the DMA base address, which the host polls.

## Interface
- TLP_QWORDS, 16: payload qwords per data TLP (128 bytes).
- COUNT_WIDTH, 10: width of the TLP-count field in DMACTRL.
- TOKEN, 64'hCAFEF00DC0DEFACE: completion token value.
- clk_in  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_wr_valid  in  1  register write strobe, one cycle per write.
- cfg_wr_index  in  1  0 = DMABASE, 1 = DMACTRL.
- cfg_wr_data  in  32  register write data.
- src_data  in  64  payload qword.
- src_valid  in  1  payload valid.
- src_ready  out  1  payload accepted when src_valid && src_ready.
- tx_data  out  64  header or payload beat.
- tx_valid  out  1  beat valid.
- tx_sop  out  1  header beat.
- tx_eop  out  1  last beat of TLP.
- tx_ready  in  1  formatter accepts beat when tx_valid && tx_ready.
- dma_busy  out  1  sequence in progress.
- dma_done  out  1  one-cycle pulse when the token beat is accepted.
- cfg_err  out  1  sticky; set when a register write is dropped.

## Operation
- DMABASE register (32b): byte address; bits [2:0] are forced to 0 on capture. DMACTRL[COUNT_WIDTH-1:0] is N, the number of data TLPs. Upper DMACTRL bits are ignored.
- In IDLE, a DMABASE write updates the base register. A DMACTRL write with N≠0 latches N, sets tlp_addr = base+64, and moves to HDR. A write with N=0 is a no-op, produces no token, and does not set cfg_err.
- Any cfg write while dma_busy is dropped and sets cfg_err. cfg_err clears only on reset.
- States:
  - IDLE
  - HDR: tx_valid=1, tx_sop=1, tx_eop=0, tx_data={tlp_addr, 22'b0, 10'd(2*TLP_QWORDS)}. On accept → DATA, beat counter = 0.
  - DATA: pass-through, with tx_data=src_data, tx_valid=src_valid, src_ready=tx_ready, tx_eop=(beat==TLP_QWORDS-1). Each transfer increments beat. On the last beat, tlp_addr += 128 (mod 2^32) and remaining decrements. If remaining was >1 → HDR, else → TOK_HDR.
  - TOK_HDR: header {base, 22'b0, 10'd2}, tx_sop=1. On accept → TOK_DATA.
  - TOK_DATA: tx_data=TOKEN, tx_valid=1, tx_eop=1. On accept → IDLE and pulse dma_done.
- src_ready=0 outside DATA. tx_valid never depends on tx_ready.
- dma_busy=1 in every state except IDLE.
- Reset mid-sequence aborts immediately to IDLE, with no token written. base, N and counters return to 0.

## Timing
- Reset values: src_ready, tx_valid, tx_sop, tx_eop, dma_busy, dma_done and cfg_err are 0; tx_data is 0.
- A DMACTRL write sampled on edge t puts the first header on tx from cycle t+1, with dma_busy=1 from t+1.
- Zero-bubble when tx_ready and src_valid are held high: each TLP takes TLP_QWORDS+1 cycles and the token takes 2 cycles. N TLPs therefore take N·(TLP_QWORDS+1)+2 cycles to dma_done.
- dma_done is registered and asserts in the cycle after the token beat's accept edge, with dma_busy=0 in that same cycle. A new DMACTRL write is accepted from that cycle.
- Header and payload beats hold stable while tx_valid && !tx_ready.
- src_valid low in DATA inserts bubbles. The beat count is unaffected.

## Test plan
- Write DMABASE=0x20 then DMACTRL=1, with a source of 16 known qwords and tx_ready=1:
  - header addr 0x60, len 32;
  - 16 payload beats in order, eop on the 16th;
  - token header addr 0x20, len 2, then 0xCAFEF00DC0DEFACE;
  - dma_done 20 cycles after the write.
- DMACTRL=3 with base 0x1000: headers at 0x1040, 0x10C0, 0x1140, then the token at 0x1000. 53 cycles total, no gaps.
- Randomized tx_ready and src_valid stalls (50%): tx beats are stable under stall, the same data order and count as the stall-free run, and exactly one dma_done.
- DMABASE=0xFFFFFFC3, N=2:
  - base captured as 0xFFFFFFC0;
  - headers at 0x00000000 and 0x00000080 (wrap);
  - token at 0xFFFFFFC0.
- Register writes during a run:
  - DMACTRL and DMABASE writes issued mid-run are dropped, cfg_err=1, and the run completes unchanged;
  - DMACTRL=0 in IDLE produces no tx activity and no cfg_err.
- Assert rstn mid-DATA: all outputs are 0 asynchronously. After release, state is IDLE with no token emitted, and a fresh DMACTRL=1 run completes normally.
